// File: rtl/pc_stack_unit.sv
// Program counter with increment/jump/relative branch and a register-based call/return stack.
// Optional PC_TRAP_EN: stack overflow/underflow redirects pc to TRAP_VEC instead of holding.
module pc_stack_unit #(
  parameter int                ADDR_W    = 8,
  parameter int                OFF_W     = 6,
  parameter int                DEPTH     = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(8'hF0)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [2:0]               op,
  input  logic [ADDR_W-1:0]        target,
  input  logic [OFF_W-1:0]         offset,
  input  logic                     clr_err,
  output logic [ADDR_W-1:0]        pc,
  output logic [$clog2(DEPTH):0]   depth,
  output logic                     stack_full,
  output logic                     stack_empty,
  output logic                     stk_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = PW + 1;

  localparam logic [2:0] OP_INC  = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_BR   = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;

  logic [ADDR_W-1:0] stack [DEPTH];
  logic [ADDR_W-1:0] pc_nxt;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] err_pc;
  logic [DW-1:0]     depth_nxt;
  logic [PW-1:0]     wr_idx;
  logic [PW-1:0]     rd_idx;
  logic              push;
  logic              err_set;

  assign stack_full  = (depth == DW'(DEPTH));
  assign stack_empty = (depth == '0);

  assign pc_inc  = pc + ADDR_W'(1);
  assign off_ext = ADDR_W'($signed(offset));
  // Push slot is the current depth; top of stack is one below it.
  assign wr_idx  = PW'(depth);
  assign rd_idx  = PW'(depth - DW'(1));

`ifdef PC_TRAP_EN
  assign err_pc = TRAP_VEC;
`else
  logic unused_trap;
  assign unused_trap = ^TRAP_VEC;
  assign err_pc      = pc;
`endif

  always_comb begin
    pc_nxt    = pc;
    depth_nxt = depth;
    push      = 1'b0;
    err_set   = 1'b0;
    if (enable) begin
      case (op)
        OP_INC: pc_nxt = pc_inc;
        OP_JMP: pc_nxt = target;
        OP_BR:  pc_nxt = pc + off_ext;
        OP_CALL: begin
          if (stack_full) begin
            err_set = 1'b1;
            pc_nxt  = err_pc;
          end else begin
            push      = 1'b1;
            depth_nxt = depth + DW'(1);
            pc_nxt    = target;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            err_set = 1'b1;
            pc_nxt  = err_pc;
          end else begin
            depth_nxt = depth - DW'(1);
            pc_nxt    = stack[rd_idx];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_VEC;
      depth   <= '0;
      stk_err <= 1'b0;
    end else begin
      pc    <= pc_nxt;
      depth <= depth_nxt;
      // A new error takes priority over a simultaneous clear.
      if (err_set)      stk_err <= 1'b1;
      else if (clr_err) stk_err <= 1'b0;
    end
  end

  // Entries above depth are never read, so the storage needs no reset.
  always_ff @(posedge clk) begin
    if (push) stack[wr_idx] <= pc_inc;
  end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Bench for pc_stack_unit: directed scenarios plus randomized ops against a queue-based model.
module tb_pc_stack_unit;

  localparam logic [7:0] RV = 8'h10;
`ifdef PC_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [7:0] TV = 8'hF0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [2:0] op;
  logic [7:0] target;
  logic [5:0] offset;
  logic       clr_err;
  logic [7:0] pc;
  logic [2:0] depth;
  logic       stack_full;
  logic       stack_empty;
  logic       stk_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] m_pc;
  logic [7:0] m_stk[$];
  logic       m_err;

  pc_stack_unit #(.ADDR_W(8), .OFF_W(6), .DEPTH(4), .RESET_VEC(RV), .TRAP_VEC(TV)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .op(op), .target(target),
    .offset(offset), .clr_err(clr_err), .pc(pc), .depth(depth),
    .stack_full(stack_full), .stack_empty(stack_empty), .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = RV;
    m_stk.delete();
    m_err = 1'b0;
  endtask

  // Reference behaviour: a call stack is a list of return addresses.
  task automatic model_step(input logic en, input logic [2:0] o, input logic [7:0] t,
                            input logic [5:0] off, input logic clr);
    bit e = 0;
    int s;
    if (en) begin
      case (o)
        3'd0: m_pc = 8'(int'(m_pc) + 1);
        3'd1: m_pc = t;
        3'd2: begin
          s = off[5] ? int'(off) - 64 : int'(off);
          m_pc = 8'(int'(m_pc) + s);
        end
        3'd3: begin
          if (m_stk.size() == 4) e = 1;
          else begin
            m_stk.push_back(8'(int'(m_pc) + 1));
            m_pc = t;
          end
        end
        3'd4: begin
          if (m_stk.size() == 0) e = 1;
          else m_pc = m_stk.pop_back();
        end
        default: ;
      endcase
      if (e && TRAP) m_pc = TV;
    end
    if (e) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
  endtask

  task automatic cycle(input logic en, input logic [2:0] o, input logic [7:0] t,
                       input logic [5:0] off, input logic clr);
    enable = en; op = o; target = t; offset = off; clr_err = clr;
    model_step(en, o, t, off, clr);
    @(posedge clk);
    #1;
    enable = 1'b0; op = 3'd5; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; op = 3'd5; target = '0; offset = '0; clr_err = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (pc !== RV) begin n_errors++; $display("FAIL reset_pc: got %h want %h", pc, RV); end
    n_checks++;
    if (depth !== 3'd0 || stack_empty !== 1'b1 || stack_full !== 1'b0 || stk_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: depth=%0d empty=%b full=%b err=%b want 0 1 0 0",
               depth, stack_empty, stack_full, stk_err);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_inc();
    logic [7:0] exp_pc;
    for (int i = 1; i <= 3; i++) begin
      cycle(1, 3'd0, 8'h00, 6'h00, 0);
      exp_pc = RV + 8'(i);
      n_checks++;
      if (pc !== exp_pc) begin n_errors++; $display("FAIL inc_%0d: got %h want %h", i, pc, exp_pc); end
    end
    cycle(1, 3'd1, 8'hFF, 6'h00, 0);
    cycle(1, 3'd0, 8'h00, 6'h00, 0);
    n_checks++;
    if (pc !== 8'h00) begin n_errors++; $display("FAIL inc_wrap: got %h want 00", pc); end
  endtask

  task automatic test_branch();
    cycle(1, 3'd1, 8'h20, 6'h00, 0);
    cycle(1, 3'd2, 8'h00, 6'h3C, 0);
    n_checks++;
    if (pc !== 8'h1C) begin n_errors++; $display("FAIL br_neg: got %h want 1c", pc); end
    cycle(1, 3'd2, 8'h00, 6'h1F, 0);
    n_checks++;
    if (pc !== 8'h3B) begin n_errors++; $display("FAIL br_pos: got %h want 3b", pc); end
    cycle(1, 3'd1, 8'h02, 6'h00, 0);
    cycle(1, 3'd2, 8'h00, 6'h20, 0);
    n_checks++;
    if (pc !== 8'hE2) begin n_errors++; $display("FAIL br_wrap: got %h want e2", pc); end
  endtask

  task automatic test_back_to_back();
    cycle(1, 3'd1, 8'h05, 6'h00, 0);
    cycle(1, 3'd3, 8'h40, 6'h00, 0);
    n_checks++;
    if (pc !== 8'h40 || depth !== 3'd1) begin n_errors++; $display("FAIL call1: pc=%h depth=%0d want 40 1", pc, depth); end
    cycle(1, 3'd3, 8'h80, 6'h00, 0);
    n_checks++;
    if (pc !== 8'h80 || depth !== 3'd2) begin n_errors++; $display("FAIL call2: pc=%h depth=%0d want 80 2", pc, depth); end
    cycle(1, 3'd4, 8'h00, 6'h00, 0);
    n_checks++;
    if (pc !== 8'h41 || depth !== 3'd1) begin n_errors++; $display("FAIL ret1: pc=%h depth=%0d want 41 1", pc, depth); end
    cycle(1, 3'd4, 8'h00, 6'h00, 0);
    n_checks++;
    if (pc !== 8'h06 || depth !== 3'd0 || stack_empty !== 1'b1) begin
      n_errors++; $display("FAIL ret2: pc=%h depth=%0d empty=%b want 06 0 1", pc, depth, stack_empty);
    end
  endtask

  task automatic test_overflow();
    logic [7:0] exp_pc;
    cycle(1, 3'd3, 8'h11, 6'h00, 0);
    cycle(1, 3'd3, 8'h22, 6'h00, 0);
    cycle(1, 3'd3, 8'h33, 6'h00, 0);
    cycle(1, 3'd3, 8'h50, 6'h00, 0);
    n_checks++;
    if (stack_full !== 1'b1 || depth !== 3'd4 || pc !== 8'h50) begin
      n_errors++; $display("FAIL full: full=%b depth=%0d pc=%h want 1 4 50", stack_full, depth, pc);
    end
    cycle(1, 3'd3, 8'h99, 6'h00, 0);
    exp_pc = TRAP ? TV : 8'h50;
    n_checks++;
    if (pc !== exp_pc || depth !== 3'd4 || stk_err !== 1'b1) begin
      n_errors++; $display("FAIL overflow: pc=%h depth=%0d err=%b want %h 4 1", pc, depth, stk_err, exp_pc);
    end
    cycle(1, 3'd5, 8'h00, 6'h00, 1);
    n_checks++;
    if (stk_err !== 1'b0) begin n_errors++; $display("FAIL clr_err: got %b want 0", stk_err); end
    for (int i = 0; i < 4; i++) begin
      cycle(1, 3'd4, 8'h00, 6'h00, 0);
      n_checks++;
      if (pc !== m_pc || depth !== 3'(m_stk.size())) begin
        n_errors++; $display("FAIL drain_%0d: pc=%h depth=%0d want %h %0d", i, pc, depth, m_pc, m_stk.size());
      end
    end
  endtask

  task automatic test_underflow();
    logic [7:0] exp_pc;
    rst_n = 1'b0; #1; rst_n = 1'b1;
    model_reset();
    cycle(1, 3'd4, 8'h00, 6'h00, 0);
    exp_pc = TRAP ? TV : RV;
    n_checks++;
    if (pc !== exp_pc || depth !== 3'd0 || stk_err !== 1'b1) begin
      n_errors++; $display("FAIL underflow: pc=%h depth=%0d err=%b want %h 0 1", pc, depth, stk_err, exp_pc);
    end
    cycle(1, 3'd4, 8'h00, 6'h00, 1);
    n_checks++;
    if (stk_err !== 1'b1) begin n_errors++; $display("FAIL err_wins: got %b want 1", stk_err); end
  endtask

  task automatic test_stall();
    logic [7:0] pc0;
    cycle(1, 3'd1, 8'h70, 6'h00, 0);
    pc0 = pc;
    cycle(0, 3'd3, 8'hAA, 6'h00, 0);
    n_checks++;
    if (pc !== 8'h70 || depth !== 3'd0) begin n_errors++; $display("FAIL stall: pc=%h depth=%0d want 70 0", pc, depth); end
    cycle(0, 3'd0, 8'h00, 6'h00, 1);
    n_checks++;
    if (stk_err !== 1'b0 || pc !== pc0) begin
      n_errors++; $display("FAIL stall_clr: err=%b pc=%h want 0 %h", stk_err, pc, pc0);
    end
  endtask

  task automatic test_async_reset();
    cycle(1, 3'd3, 8'h21, 6'h00, 0);
    cycle(1, 3'd3, 8'h31, 6'h00, 0);
    cycle(1, 3'd3, 8'h41, 6'h00, 0);
    n_checks++;
    if (depth !== 3'd3) begin n_errors++; $display("FAIL pre_rst_depth: got %0d want 3", depth); end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (pc !== RV || depth !== 3'd0) begin
      n_errors++; $display("FAIL async_rst: pc=%h depth=%0d want %h 0", pc, depth, RV);
    end
    #1;
    rst_n = 1'b1;
    cycle(1, 3'd4, 8'h00, 6'h00, 0);
    n_checks++;
    if (stk_err !== 1'b1 || depth !== 3'd0) begin
      n_errors++; $display("FAIL rst_then_ret: err=%b depth=%0d want 1 0", stk_err, depth);
    end
  endtask

  task automatic test_random();
    logic [2:0] o;
    for (int i = 0; i < 400; i++) begin
      o = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) o = 3'd3;
      cycle(($urandom_range(0, 9) != 0), o, 8'($urandom), 6'($urandom), ($urandom_range(0, 5) == 0));
      n_checks++;
      if (pc !== m_pc) begin n_errors++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc, m_pc); end
      n_checks++;
      if (depth !== 3'(m_stk.size()) || stack_full !== (m_stk.size() == 4) || stack_empty !== (m_stk.size() == 0)) begin
        n_errors++; $display("FAIL rnd_depth[%0d]: got %0d/%b/%b want %0d", i, depth, stack_full, stack_empty, m_stk.size());
      end
      n_checks++;
      if (stk_err !== m_err) begin n_errors++; $display("FAIL rnd_err[%0d]: got %b want %b", i, stk_err, m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_inc();
    test_branch();
    test_back_to_back();
    test_overflow();
    test_underflow();
    test_stall();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
- Parametrised program-counter unit; next generation of the 8-bit increment/load instruction pointer.
- Adds generic address width, signed relative branch, and a hardware call/return stack with depth tracking and error flags.
- Sits between the control unit (op decode, enable) and instruction memory (pc drives the fetch address).

Parameters:
ADDR_W, 8, width of pc, target and stack entries
OFF_W, 6, width of signed relative-branch offset (OFF_W <= ADDR_W)
DEPTH, 4, call-stack entries (power of two, >= 2)
RESET_VEC, 0, pc value after reset
TRAP_VEC, 8'hF0 (sized to ADDR_W), trap target; used only with PC_TRAP_EN

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
enable  in  1  advance/update strobe; low = stall, all state held
op  in  3  0 INC, 1 JMP, 2 BR, 3 CALL, 4 RET, 5 HOLD, 6-7 reserved (act as HOLD)
target  in  ADDR_W  absolute destination for JMP/CALL
offset  in  OFF_W  signed two's-complement offset for BR
clr_err  in  1  clears sticky stk_err
pc  out  ADDR_W  current program counter (registered)
depth  out  clog2(DEPTH)+1  number of valid stack entries
stack_full  out  1  depth == DEPTH (combinational from depth)
stack_empty  out  1  depth == 0
stk_err  out  1  sticky: overflow or underflow occurred

Behaviour:
- Reset (async, rst_n low): pc = RESET_VEC, depth = 0, stk_err = 0. Stack RAM contents are don't-care. Release takes effect on the next clk edge.
- All updates occur on rising clk only when enable = 1. With enable = 0, pc, depth and stack are held; clr_err is still honoured.
- INC: pc <= pc + 1, modulo 2^ADDR_W (all-ones wraps to 0).
- JMP: pc <= target.
- BR: pc <= pc + sign_extend(offset), modulo 2^ADDR_W. The base is the current pc, not pc+1.
- CALL, not full: stack[depth] <= pc + 1 (wrapped), depth <= depth + 1, pc <= target.
- CALL when full (overflow): no push, depth unchanged, pc held, stk_err <= 1.
- RET, not empty: pc <= stack[depth-1], depth <= depth - 1.
- RET when empty (underflow): pc held, depth stays 0, stk_err <= 1.
- HOLD and reserved codes: no change.
- Each op has single-cycle latency; the new pc is visible on the output right after the edge.
- Back-to-back CALL/RET on consecutive cycles must work with no bubble. A RET immediately after a CALL returns the address pushed on the previous cycle.
- clr_err and a new error in the same cycle: the error wins (stk_err = 1).
- Reset mid-sequence discards the stack (depth = 0). A subsequent RET underflows.
- Stack storage is plain registers, not addressed RAM (small DEPTH).

Optional Feature:
Macro PC_TRAP_EN.
- Defined: on overflow or underflow, pc <= TRAP_VEC instead of holding. stk_err is still set, and depth is unchanged.
- Undefined: pc holds on stack errors as described above, and TRAP_VEC is unused.

Test Plan:
- Reset with RESET_VEC = 8'h10, then 3 cycles of INC with enable = 1 -> pc = 10, 11, 12, 13. Set pc = 8'hFF, INC -> pc = 8'h00.
- pc = 8'h20: BR offset = 6'h3C (-4) -> pc = 8'h1C. BR offset = 6'h1F -> pc = 8'h3B.
- pc = 8'h05: CALL target 8'h40 -> pc = 40, depth = 1. Next cycle CALL 8'h80 -> pc = 80, depth = 2. RET -> pc = 41, depth = 1. RET -> pc = 06, depth = 0, stack_empty = 1.
- Overflow: 4 CALLs reach stack_full = 1; a 5th CALL at pc = 8'h50 -> pc stays 50 (or F0 with PC_TRAP_EN), depth = 4, stk_err = 1. Then clr_err -> stk_err = 0.
- Underflow: from reset, RET -> pc = RESET_VEC (or TRAP_VEC with PC_TRAP_EN), stk_err = 1. RET together with clr_err -> stk_err stays 1.
- Stall/reset: CALL with enable = 0 -> no change to pc or depth. Assert rst_n low asynchronously mid-clock at depth 3 -> pc = RESET_VEC and depth = 0 immediately, with no clk edge required.
